// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared constants for the storage element
package dff_pkg;

    // Natural width of a single bitcell storage element
    localparam int DFF_DEFAULT_WIDTH = 1;

endpackage : dff_pkg

// File: rtl/dff.sv
// rtl/dff.sv - write-enabled storage element with true and complement outputs
module dff
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             we,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Reset has priority over a write; without either, the stored value holds
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= RESET_VAL;
        end else if (we) begin
            Q <= data;
        end
    end

    // Complement is derived from the stored value only, never from data or we
    assign Qn = ~Q;

endmodule : dff

// File: tb/tb_dff.sv
// tb/tb_dff.sv - self-checking bench for the storage element
module tb_dff;

    localparam int        WW    = 8;
    localparam logic [WW-1:0] WRST = 8'hA5;

    logic          clk;
    logic          rst;
    logic [0:0]    data;
    logic          we;
    logic [0:0]    q;
    logic [0:0]    qn;

    logic          rst_w;
    logic [WW-1:0] data_w;
    logic          we_w;
    logic [WW-1:0] q_w;
    logic [WW-1:0] qn_w;

    int tests_run;
    int tests_failed;

    dff u_bit (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .we   (we),
        .Q    (q),
        .Qn   (qn)
    );

    dff #(.WIDTH(WW), .RESET_VAL(WRST)) u_word (
        .clk  (clk),
        .rst  (rst_w),
        .data (data_w),
        .we   (we_w),
        .Q    (q_w),
        .Qn   (qn_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; data = 1'b1; we = 1'b1;
        tick();
        tests_run++;
        if (q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_q: got %b expected 0", q);
        end
        tests_run++;
        if (qn !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_qn: got %b expected 1", qn);
        end
    endtask

    task automatic test_write;
        rst = 1'b0; data = 1'b1; we = 1'b1;
        #1;
        tests_run++;
        if (q !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_before_edge: got %b expected 0", q);
        end
        tick();
        tests_run++;
        if (q !== 1'b1 || qn !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_q_qn: got Q=%b Qn=%b expected Q=1 Qn=0", q, qn);
        end
    endtask

    task automatic test_hold;
        we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data = 1'(i);
            tick();
            tests_run++;
            if (q !== 1'b1 || qn !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: got Q=%b Qn=%b expected Q=1 Qn=0", i, q, qn);
            end
        end
    endtask

    task automatic test_overwrite;
        we = 1'b1; data = 1'b0;
        tick();
        tests_run++;
        if (q !== 1'b0 || qn !== 1'b1) begin
            tests_failed++;
            $display("FAIL overwrite: got Q=%b Qn=%b expected Q=0 Qn=1", q, qn);
        end
        we = 1'b0; data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (q !== 1'b0) begin
                tests_failed++;
                $display("FAIL overwrite_hold_%0d: got %b expected 0", i, q);
            end
        end
    endtask

    task automatic test_priority;
        we = 1'b1; data = 1'b1;
        tick();
        tests_run++;
        if (q !== 1'b1) begin
            tests_failed++;
            $display("FAIL priority_setup: got %b expected 1", q);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (q !== 1'b0 || qn !== 1'b1) begin
            tests_failed++;
            $display("FAIL priority_reset_wins: got Q=%b Qn=%b expected Q=0 Qn=1", q, qn);
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_bitcell;
        logic [2:0] steps [3];   // {inp, rw, sel}
        logic [0:0] expq [3];
        steps[0] = 3'b110; expq[0] = 1'b0;
        steps[1] = 3'b111; expq[1] = 1'b1;
        steps[2] = 3'b101; expq[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = steps[i][2];
            we   = steps[i][1] & steps[i][0];
            tick();
            tests_run++;
            if (q !== expq[i] || qn !== ~expq[i]) begin
                tests_failed++;
                $display("FAIL bitcell_%0d: got Q=%b Qn=%b expected Q=%b Qn=%b",
                         i, q, qn, expq[i], ~expq[i]);
            end
        end
        we = 1'b0;
    endtask

    task automatic test_random_wide;
        logic [WW-1:0] model;
        rst_w = 1'b1; we_w = 1'b1; data_w = $urandom();
        tick();
        model = WRST;
        tests_run++;
        if (q_w !== model || qn_w !== ~model) begin
            tests_failed++;
            $display("FAIL wide_reset: got Q=%h Qn=%h expected Q=%h Qn=%h", q_w, qn_w, model, ~model);
        end
        for (int i = 0; i < 300; i++) begin
            rst_w  = ($urandom_range(15) == 0);
            we_w   = $urandom_range(1);
            data_w = $urandom();
            #1;
            tests_run++;
            if (q_w !== model) begin
                tests_failed++;
                $display("FAIL wide_no_comb_%0d: got %h expected %h", i, q_w, model);
            end
            if (rst_w)     model = WRST;
            else if (we_w) model = data_w;
            tick();
            tests_run++;
            if (q_w !== model || qn_w !== ~model) begin
                tests_failed++;
                $display("FAIL wide_rand_%0d: got Q=%h Qn=%h expected Q=%h Qn=%h",
                         i, q_w, qn_w, model, ~model);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0; data = 1'b0; we = 1'b0;
        rst_w = 1'b0; data_w = '0; we_w = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_hold();
        test_overwrite();
        test_priority();
        test_bitcell();
        test_random_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dff
